// File: rtl/sysarray_pkg.sv
// Shared types and constants for the sysarray sequencer.
//   state_t  : controller FSM states
//   FLG_W    : width of the array flg control bus
//   IDLE_FLG : flg value that keeps the array out of load mode
//   elem_w() : element width from its MSB index
package sysarray_pkg;

    localparam int unsigned FLG_W = 7;
    localparam logic [FLG_W-1:0] IDLE_FLG = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned elem_w(input int unsigned msb);
        return msb + 1;
    endfunction

endpackage

// File: rtl/sysarray_if.sv
// Host-side bus of the sysarray sequencer: job start, operand stream,
// result stream and status.
//   master : host / operand buffer (drives start, op_valid, op_a, op_b)
//   slave  : sysarray_ctrl (drives op_ready, res_*, busy, done, err)
interface sysarray_if
    import sysarray_pkg::*;
#(
    parameter int unsigned N       = 31,
    parameter int unsigned n       = 3,
    parameter int unsigned RES_CNT = 3
);
    localparam int unsigned EW = elem_w(N);
    localparam int unsigned IW = $clog2(RES_CNT + 1);

    logic            start;
    logic            op_valid;
    logic            op_ready;
    logic [EW*n-1:0] op_a;
    logic [EW*n-1:0] op_b;
    logic            res_valid;
    logic [EW-1:0]   res_data;
    logic [IW-1:0]   res_idx;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, op_valid, op_a, op_b,
        input  op_ready, res_valid, res_data, res_idx, busy, done, err
    );

    modport slave (
        input  start, op_valid, op_a, op_b,
        output op_ready, res_valid, res_data, res_idx, busy, done, err
    );

endinterface

// File: rtl/sysarray_ctrl.sv
// Sequencer for one sysarray instance: loads n contiguous operand beats
// (flg = 0..n-1), drains the array for DRAIN_CYC cycles, captures RES_CNT
// dpin samples starting at drain cycle RES_LAT, then pulses done.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : host bus (slave side), see sysarray_if
//   flg        : array load index, IDLE_FLG when not loading
//   arr1, arr2 : array operand inputs (row / column slices)
//   dpin       : array result output
module sysarray_ctrl
    import sysarray_pkg::*;
#(
    parameter int unsigned N         = 31,
    parameter int unsigned n         = 3,
    parameter int unsigned RES_LAT   = 9,
    parameter int unsigned RES_CNT   = 3,
    parameter int unsigned DRAIN_CYC = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sysarray_if.slave              bus,
    output logic [FLG_W-1:0]       flg,
    output logic [elem_w(N)*n-1:0] arr1,
    output logic [elem_w(N)*n-1:0] arr2,
    input  logic [elem_w(N)-1:0]   dpin
);

    localparam int unsigned EW = elem_w(N);
    localparam int unsigned BW = EW * n;
    localparam int unsigned KW = $clog2(n + 1);
    localparam int unsigned CW = $clog2(DRAIN_CYC + 1);
    localparam int unsigned IW = $clog2(RES_CNT + 1);

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    c_q, c_d;
    logic [FLG_W-1:0] flg_d;
    logic [BW-1:0]    arr1_d, arr2_d;
    logic             op_ready_d, res_valid_d, busy_d, done_d, err_d;
    logic [EW-1:0]    res_data_d;
    logic [IW-1:0]    res_idx_d;

    // State, counters and every output are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            c_q           <= '0;
            flg           <= IDLE_FLG;
            arr1          <= '0;
            arr2          <= '0;
            bus.op_ready  <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_idx   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            c_q           <= c_d;
            flg           <= flg_d;
            arr1          <= arr1_d;
            arr2          <= arr2_d;
            bus.op_ready  <= op_ready_d;
            bus.res_valid <= res_valid_d;
            bus.res_data  <= res_data_d;
            bus.res_idx   <= res_idx_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
            bus.err       <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c_d         = c_q;
        flg_d       = IDLE_FLG;
        arr1_d      = '0;
        arr2_d      = '0;
        res_valid_d = 1'b0;
        res_data_d  = bus.res_data;
        res_idx_d   = bus.res_idx;
        err_d       = 1'b0;
        op_ready_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    k_d     = '0;
                end
            end
            LOAD: begin
                if (bus.op_valid) begin
                    flg_d  = FLG_W'(k_q);
                    arr1_d = bus.op_a;
                    arr2_d = bus.op_b;
                    k_d    = k_q + 1'b1;
                    if (k_q == KW'(n - 1)) begin
                        state_d = DRAIN;
                        k_d     = '0;
                        c_d     = '0;
                    end
                end else if (k_q != '0) begin
                    // A gap after beat 0 breaks the operand skew: abort the job.
                    err_d   = 1'b1;
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                c_d = c_q + 1'b1;
                if (c_q >= CW'(RES_LAT) && c_q < CW'(RES_LAT + RES_CNT)) begin
                    res_valid_d = 1'b1;
                    res_data_d  = dpin;
                    res_idx_d   = IW'(c_q - CW'(RES_LAT));
                end
                if (c_q == CW'(DRAIN_CYC - 1)) begin
                    c_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs follow the state being entered so they align with it.
        op_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

endmodule

// File: tb/tb_sysarray_ctrl.sv
// Self-checking bench for sysarray_ctrl: timeline of each job is predicted
// from the load/drain rules with plain arithmetic, dpin is random per cycle.
module tb_sysarray_ctrl;

    localparam int unsigned N         = 31;
    localparam int unsigned NN        = 3;
    localparam int unsigned RES_LAT   = 9;
    localparam int unsigned RES_CNT   = 3;
    localparam int unsigned DRAIN_CYC = 14;
    localparam int unsigned EW        = N + 1;
    localparam int unsigned BW        = EW * NN;
    localparam int unsigned IW        = $clog2(RES_CNT + 1);
    localparam logic [6:0]  FLG_IDLE  = 7'h7F;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    flg;
    logic [BW-1:0] arr1, arr2;
    logic [EW-1:0] dpin  = '0;

    sysarray_if #(.N(N), .n(NN), .RES_CNT(RES_CNT)) bus ();

    sysarray_ctrl #(
        .N(N), .n(NN), .RES_LAT(RES_LAT), .RES_CNT(RES_CNT), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .flg(flg), .arr1(arr1), .arr2(arr2), .dpin(dpin)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            passes = 0;
    int            cyc    = 0;
    logic [EW-1:0] dpin_hist [0:4095];
    logic [BW-1:0] ja [NN];
    logic [BW-1:0] jb [NN];
    int            res_seen;
    bit            done_seen;
    int            job_len;

    // One clock: fresh random dpin for the coming edge (index cyc), then settle.
    task automatic tick();
        dpin = EW'($urandom());
        dpin_hist[cyc % 4096] = dpin;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_operands();
        for (int j = 0; j < NN; j++)
            for (int i = 0; i < NN; i++) begin
                ja[j][i*EW +: EW] = EW'($urandom());
                jb[j][i*EW +: EW] = EW'($urandom());
            end
    endtask

    // Drives one job. w: idle cycles before beat 0; drop_at: beat index where
    // op_valid is withdrawn (-1 none); sid: start pulse at drain c=5;
    // rst10: reset at drain c=10.
    task automatic run_job(input string tag, input int w, input int drop_at,
                           input bit sid, input bit rst10);
        int e_s, e_l, e, c;
        bit exp_v, exp_d;
        res_seen = 0; done_seen = 0; job_len = 0;
        bus.start = 1'b1; e_s = cyc; tick(); bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.op_ready !== 1'b1)
            $display("FAIL %s start_ack busy=%b op_ready=%b want 1 1", tag, bus.busy, bus.op_ready);
        else passes++;
        for (int i = 0; i < w; i++) begin
            bus.op_valid = 1'b0; tick();
            checks++;
            if (flg !== FLG_IDLE || bus.err !== 1'b0 || bus.op_ready !== 1'b1)
                $display("FAIL %s wait flg=%h err=%b op_ready=%b want 7f 0 1", tag, flg, bus.err, bus.op_ready);
            else passes++;
        end
        for (int j = 0; j < NN; j++) begin
            if (j == drop_at) begin
                bus.op_valid = 1'b0; tick();
                checks++;
                if (bus.err !== 1'b1 || flg !== FLG_IDLE || bus.busy !== 1'b0 || arr1 !== '0 || arr2 !== '0)
                    $display("FAIL %s underrun err=%b flg=%h busy=%b want 1 7f 0", tag, bus.err, flg, bus.busy);
                else passes++;
                for (int i = 0; i < DRAIN_CYC + 4; i++) begin
                    tick();
                    checks++;
                    if (bus.err !== 1'b0 || bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
                        $display("FAIL %s post_abort err=%b res_valid=%b done=%b busy=%b want 0", tag, bus.err, bus.res_valid, bus.done, bus.busy);
                    else passes++;
                end
                return;
            end
            bus.op_valid = 1'b1; bus.op_a = ja[j]; bus.op_b = jb[j]; tick();
            checks++;
            if (flg !== 7'(j) || arr1 !== ja[j] || arr2 !== jb[j])
                $display("FAIL %s beat%0d flg=%h want %h arr1=%h want %h", tag, j, flg, 7'(j), arr1, ja[j]);
            else passes++;
        end
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        e_l = cyc - 1;
        for (int i = 0; i < int'(DRAIN_CYC) + 4 && !done_seen; i++) begin
            e = cyc;
            c = e - e_l - 1;
            if (rst10 && c == 10) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
                checks++;
                if (flg !== FLG_IDLE || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.done !== 1'b0 ||
                    bus.err !== 1'b0 || bus.op_ready !== 1'b0 || bus.res_data !== '0 || bus.res_idx !== '0 || arr1 !== '0)
                    $display("FAIL %s mid_reset flg=%h busy=%b res_valid=%b done=%b res_data=%h", tag, flg, bus.busy, bus.res_valid, bus.done, bus.res_data);
                else passes++;
                for (int k = 0; k < DRAIN_CYC + 4; k++) begin
                    tick();
                    checks++;
                    if (bus.res_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0)
                        $display("FAIL %s post_reset res_valid=%b done=%b busy=%b err=%b want 0", tag, bus.res_valid, bus.done, bus.busy, bus.err);
                    else passes++;
                end
                return;
            end
            if (sid && c == 5) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            exp_v = (c >= int'(RES_LAT) && c < int'(RES_LAT + RES_CNT));
            exp_d = (e == e_l + int'(DRAIN_CYC));
            checks++;
            if (bus.res_valid !== exp_v || bus.done !== exp_d || flg !== FLG_IDLE || arr1 !== '0 || bus.op_ready !== 1'b0)
                $display("FAIL %s drain c=%0d res_valid=%b want %b done=%b want %b flg=%h", tag, c, bus.res_valid, exp_v, bus.done, exp_d, flg);
            else passes++;
            if (exp_v) begin
                checks++;
                if (bus.res_data !== dpin_hist[e % 4096] || bus.res_idx !== IW'(c - int'(RES_LAT)))
                    $display("FAIL %s result c=%0d data=%h want %h idx=%0d want %0d", tag, c, bus.res_data, dpin_hist[e % 4096], bus.res_idx, c - int'(RES_LAT));
                else passes++;
            end
            if (bus.res_valid === 1'b1) res_seen++;
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                job_len = cyc - e_s + 1;
            end
        end
        checks++;
        if (!done_seen) $display("FAIL %s done_timeout done=%b want 1", tag, bus.done);
        else passes++;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b0)
            $display("FAIL %s after_done done=%b busy=%b op_ready=%b want 0 0 0", tag, bus.done, bus.busy, bus.op_ready);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (flg !== FLG_IDLE || bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.err !== 1'b0 || arr1 !== '0 || arr2 !== '0 || bus.res_data !== '0 || bus.res_idx !== '0)
            $display("FAIL reset flg=%h busy=%b op_ready=%b res_valid=%b done=%b err=%b", flg, bus.busy, bus.op_ready, bus.res_valid, bus.done, bus.err);
        else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        for (int j = 0; j < NN; j++)
            for (int i = 0; i < NN; i++) begin
                ja[j][i*EW +: EW] = EW'(j * NN + i + 1);
                jb[j][i*EW +: EW] = (i == j) ? EW'(1) : EW'(0);
            end
        run_job("nominal", 0, -1, 1'b0, 1'b0);
        checks++;
        if (res_seen != int'(RES_CNT) || job_len != int'(1 + NN + DRAIN_CYC + 1))
            $display("FAIL nominal_len res_pulses=%0d want %0d job_len=%0d want %0d", res_seen, RES_CNT, job_len, 1 + NN + DRAIN_CYC + 1);
        else passes++;
    endtask

    task automatic test_delayed_first_beat();
        rand_operands();
        run_job("delayed", 5, -1, 1'b0, 1'b0);
        checks++;
        if (res_seen != int'(RES_CNT) || job_len != int'(1 + NN + DRAIN_CYC + 1) + 5)
            $display("FAIL delayed_len res_pulses=%0d job_len=%0d want %0d", res_seen, job_len, 1 + NN + DRAIN_CYC + 1 + 5);
        else passes++;
    endtask

    task automatic test_underrun();
        rand_operands();
        run_job("underrun", 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        rand_operands();
        run_job("b2b_first", 0, -1, 1'b1, 1'b0);
        checks++;
        if (job_len != int'(1 + NN + DRAIN_CYC + 1))
            $display("FAIL b2b_first_len job_len=%0d want %0d", job_len, 1 + NN + DRAIN_CYC + 1);
        else passes++;
        rand_operands();
        run_job("b2b_second", 0, -1, 1'b0, 1'b0);
        checks++;
        if (res_seen != int'(RES_CNT) || job_len != int'(1 + NN + DRAIN_CYC + 1))
            $display("FAIL b2b_second_len res_pulses=%0d job_len=%0d want %0d", res_seen, job_len, 1 + NN + DRAIN_CYC + 1);
        else passes++;
    endtask

    task automatic test_reset_mid_job();
        rand_operands();
        run_job("midreset", 0, -1, 1'b0, 1'b1);
        checks++;
        if (res_seen != 1 || done_seen)
            $display("FAIL midreset_pulses res_pulses=%0d want 1 done_seen=%b want 0", res_seen, done_seen);
        else passes++;
        rand_operands();
        run_job("after_reset", 0, -1, 1'b0, 1'b0);
        checks++;
        if (job_len != int'(1 + NN + DRAIN_CYC + 1))
            $display("FAIL after_reset_len job_len=%0d want %0d", job_len, 1 + NN + DRAIN_CYC + 1);
        else passes++;
    endtask

    task automatic test_random_jobs();
        int w;
        for (int t = 0; t < 4; t++) begin
            rand_operands();
            w = int'($urandom_range(0, 3));
            run_job("random", w, -1, 1'b0, 1'b0);
            checks++;
            if (job_len != int'(1 + NN + DRAIN_CYC + 1) + w)
                $display("FAIL random_len job_len=%0d want %0d", job_len, 1 + NN + DRAIN_CYC + 1 + w);
            else passes++;
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        test_reset();
        test_nominal();
        test_delayed_first_beat();
        test_underrun();
        test_back_to_back();
        test_reset_mid_job();
        test_random_jobs();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/sysarray_ctrl.md
# sysarray_ctrl

Sequencer for the `sysarray` systolic matrix-multiply datapath.
- Accepts a start request and streams `n` operand beats from an upstream source into the array's `arr1`/`arr2` ports, driving the `flg` load index 0..n-1.
- Then holds the array in drain mode, captures `RES_CNT` consecutive `dpin` samples as results, and pulses `done`.
- Sits between the operand buffer/host interface and one `sysarray` instance; owns all of the array's control inputs.

## Interface
Parameters:
- `N`, 31: MSB index of one element (element width N+1).
- `n`, 3: matrix dimension; operand beats per job.
- `RES_LAT`, 9: drain cycle index of the first valid `dpin` sample.
- `RES_CNT`, 3: number of `dpin` samples captured per job.
- `DRAIN_CYC`, 14: total drain cycles; must be ≥ RES_LAT+RES_CNT.

Ports:
- `clk`  in  1  clock. One clock domain; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  job request, sampled in IDLE only.
- `op_valid`  in  1  operand beat valid.
- `op_ready`  out  1  controller accepts a beat.
- `op_a`  in  (N+1)*n  row slice for `arr1`, element i at bits [i*(N+1)+N : i*(N+1)].
- `op_b`  in  (N+1)*n  column slice for `arr2`, same packing.
- `flg`  out  7  to array `flg`.
- `arr1`, `arr2`  out  (N+1)*n  to array.
- `dpin`  in  N+1  from array `dpin`.
- `res_valid`  out  1  result sample valid (1 cycle per sample).
- `res_data`  out  N+1  result sample.
- `res_idx`  out  $clog2(RES_CNT+1)  index of current sample.
- `busy`  out  1  high in any state but IDLE.
- `done`  out  1  one-cycle pulse, job complete.
- `err`  out  1  one-cycle pulse, operand underrun abort.

## Operation
States:
- **IDLE**: `start` → LOAD, beat counter k=0.
- **LOAD**:
  - `op_ready`=1. On `op_valid`: register `flg`<=k, `arr1`<=`op_a`, `arr2`<=`op_b`, k++.
  - On accepting beat n-1 → DRAIN, c=0.
  - Skew integrity requires contiguous beats. Once beat 0 is accepted, `op_valid` low in LOAD → `err` pulse, `flg`<=IDLE_FLG, `arr1`/`arr2`<=0, → IDLE.
  - Before beat 0, waiting is allowed: `flg` stays IDLE_FLG.
- **DRAIN**:
  - `flg`=IDLE_FLG (7'h7F), `arr1`/`arr2`=0, c increments each cycle.
  - For RES_LAT ≤ c < RES_LAT+RES_CNT: `res_valid`<=1, `res_data`<=`dpin`, `res_idx`<=c-RES_LAT.
  - At c = DRAIN_CYC-1 → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.

Rules:
- All outputs are registered.
- `flg` is never between n and 126. It is either a valid load index (0..n-1) or 7'h7F.
- `start` outside IDLE is ignored; no queuing.

## Timing
- Reset values: state IDLE, `flg`=7'h7F, `arr1`=`arr2`=0, `op_ready`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `busy`=0, `done`=0, `err`=0. Counters are 0.
- `start` at edge t → `busy`, `op_ready` high from t+1.
- Beat accepted at edge t → `flg`/`arr*` visible at t+1.
- Job length with no waiting: 1 (IDLE→LOAD) + n + DRAIN_CYC + 1 cycles from `start` to `done` (defaults: 19).
- c=0 is the first cycle after the edge that registers beat n-1.
- Back-to-back jobs: `start` sampled in the cycle after `done` (IDLE) is accepted. Minimum gap is 1 cycle.
- `rst_n` low mid-job: all state and outputs return to reset values at that edge. No `done` or `err` is pulsed.

## Structure
- Shared package `sysarray_pkg`:
  - state enum {IDLE, LOAD, DRAIN, DONE};
  - `IDLE_FLG` = 7'h7F;
  - `FLG_W` = 7;
  - element width helper.
- Single module with one FSM plus counters k and c. No sub-module is natural. The array instance lives in the parent.

## Test plan
- Reset: hold `rst_n`=0 three cycles → `flg`=7'h7F, `busy`=0, all valids 0.
- Nominal job, n=3, operands contiguous with A=[[1,2,3],[4,5,6],[7,8,9]] and B=identity:
  - `flg` sequence 0,1,2 then 7F;
  - exactly 3 `res_valid` pulses at c=9..11 with `res_idx` 0,1,2;
  - `done` 19 cycles after `start`.
- Delayed first beat: `op_valid` low 5 cycles after `start` → `flg` stays 7F, no `err`; the job then completes normally with `done` at 24 cycles.
- Underrun: drop `op_valid` after beat 1 → `err` pulse next cycle, `flg`=7F, `busy`=0, no `res_valid`/`done`.
- `start` asserted during DRAIN → ignored. `start` in the cycle after `done` → second job runs, with both jobs' results correct against a golden model.
- `rst_n` low at c=10 → no further `res_valid`, `done` never pulses; a new job after reset completes normally.
